// File: rtl/axi_aw_addr_gen_pkg.sv
// Shared AXI constants and controller select decode for the NOU AW address generator.
package axi_aw_addr_gen_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef enum logic [2:0] {
    SEL_LOAD,
    SEL_HDR,
    SEL_HDR_LAST,
    SEL_DAT,
    SEL_NONE,
    SEL_ILLEGAL
  } sel_e;

  // HDR leaves base as don't-care; DAT needs base low so {pkt,base,incr}=111 stays illegal.
  function automatic sel_e decode_sel(input logic valid, input logic pkt,
                                      input logic base, input logic incr);
    sel_e s;
    if (!valid) begin
      s = SEL_NONE;
    end else begin
      case ({pkt, base, incr})
        3'b010:         s = SEL_LOAD;
        3'b001, 3'b011: s = SEL_HDR;
        3'b110:         s = SEL_HDR_LAST;
        3'b101:         s = SEL_DAT;
        default:        s = SEL_ILLEGAL;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_aw_addr_gen_out_cnt.sv
// Outstanding-transaction tracker: up/down count of issued requests awaiting a response.
module axi_out_cnt_tracker #(
  parameter int unsigned MAX_OUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] cnt_o,
  output logic       avail_o,
  output logic       underflow_o
);

  localparam logic [7:0] MaxCnt = 8'(MAX_OUT);

  logic [7:0] cnt_q, cnt_d;
  logic       uflow_q, uflow_d;

  always_comb begin
    cnt_d   = cnt_q;
    uflow_d = uflow_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + 8'd1;
    end else if (!inc_i && dec_i) begin
      // A response with nothing outstanding is flagged, never allowed to wrap the count.
      if (cnt_q == 8'd0) uflow_d = 1'b1;
      else               cnt_d   = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      uflow_q <= uflow_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign avail_o     = (cnt_q < MaxCnt);
  assign underflow_o = uflow_q;

endmodule

// File: rtl/axi_aw_addr_gen.sv
// AW-channel address generator: header/data pointers driven by controller selects, single-beat writes.
module axi_aw_addr_gen
  import axi_aw_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned FLIT_BYTES = 32,
  parameter int unsigned MAX_OUT    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              addr_valid,
  input  logic              sel_pkt_addr,
  input  logic              sel_base_addr,
  input  logic              sel_incr_addr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] pkt_addr,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic [2:0]        axi_awsize,
  output logic [1:0]        axi_awburst,
  output logic [ID_W-1:0]   axi_awid,
  input  logic              axi_bvalid,
  input  logic [1:0]        axi_bresp,
  output logic              axi_bready,
  output logic [7:0]        out_cnt,
  output logic              idle,
  output logic [2:0]        err
);

  localparam logic [ADDR_W-1:0] Stride = ADDR_W'(FLIT_BYTES);

  sel_e              sel;
  logic              issue_sel;
  logic              avail;
  logic              aw_hs, b_hs;
  logic              uflow;
  logic [ADDR_W-1:0] hdr_ptr_q, hdr_ptr_d;
  logic [ADDR_W-1:0] dat_ptr_q, dat_ptr_d;
  logic [1:0]        err_q, err_d;
  logic              bready_q;

  assign sel       = decode_sel(addr_valid, sel_pkt_addr, sel_base_addr, sel_incr_addr);
  assign issue_sel = sel inside {SEL_HDR, SEL_HDR_LAST, SEL_DAT};

  // Gated by rstn so awvalid falls the instant reset asserts, even with selects still high.
  assign axi_awvalid = rstn & issue_sel & avail;
  assign aw_hs       = axi_awvalid & axi_awready;
  assign b_hs        = axi_bvalid & bready_q;

  always_comb begin
    axi_awaddr = '0;
    if (sel == SEL_DAT)  axi_awaddr = dat_ptr_q;
    else if (issue_sel)  axi_awaddr = hdr_ptr_q;
  end

  always_comb begin
    hdr_ptr_d = hdr_ptr_q;
    dat_ptr_d = dat_ptr_q;
    if (sel == SEL_LOAD) begin
      hdr_ptr_d = base_addr;
      dat_ptr_d = pkt_addr;
    end else if (aw_hs) begin
      if (sel == SEL_DAT) dat_ptr_d = dat_ptr_q + Stride;
      else                hdr_ptr_d = hdr_ptr_q + Stride;
    end
  end

  always_comb begin
    err_d = err_q;
    if (sel == SEL_ILLEGAL)                  err_d[0] = 1'b1;
    if (b_hs && axi_bresp != AXI_RESP_OKAY)  err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr_ptr_q <= '0;
      dat_ptr_q <= '0;
      err_q     <= '0;
      bready_q  <= 1'b0;
    end else begin
      hdr_ptr_q <= hdr_ptr_d;
      dat_ptr_q <= dat_ptr_d;
      err_q     <= err_d;
      bready_q  <= 1'b1;
    end
  end

  axi_out_cnt_tracker #(
    .MAX_OUT(MAX_OUT)
  ) u_out_cnt (
    .clk        (clk),
    .rst_n      (rstn),
    .inc_i      (aw_hs),
    .dec_i      (b_hs),
    .cnt_o      (out_cnt),
    .avail_o    (avail),
    .underflow_o(uflow)
  );

  assign axi_awlen   = AXI_LEN_SINGLE;
  assign axi_awsize  = 3'($clog2(FLIT_BYTES));
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awid    = ID_W'(AXI_ID);
  assign axi_bready  = bready_q;
  assign idle        = (out_cnt == 8'd0);
  assign err         = {uflow, err_q};

endmodule

// File: tb/tb_axi_aw_addr_gen.sv
// Directed bench for axi_aw_addr_gen; dut uses MAX_OUT=8, dut_t uses MAX_OUT=2 on the same stimulus.
module tb_axi_aw_addr_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        addr_valid, sel_pkt_addr, sel_base_addr, sel_incr_addr;
  logic [31:0] base_addr, pkt_addr;
  logic        awready, bvalid;
  logic [1:0]  bresp;

  logic        awvalid, bready, idle;
  logic [31:0] awaddr;
  logic [7:0]  awlen, out_cnt;
  logic [2:0]  awsize, err;
  logic [1:0]  awburst;
  logic [3:0]  awid;

  logic        t_awvalid, t_bready, t_idle;
  logic [31:0] t_awaddr;
  logic [7:0]  t_awlen, t_out_cnt;
  logic [2:0]  t_awsize, t_err;
  logic [1:0]  t_awburst;
  logic [3:0]  t_awid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_aw_addr_gen #(.ADDR_W(32), .ID_W(4), .AXI_ID(0), .FLIT_BYTES(32), .MAX_OUT(8)) dut (
    .clk(clk), .rstn(rstn), .addr_valid(addr_valid), .sel_pkt_addr(sel_pkt_addr),
    .sel_base_addr(sel_base_addr), .sel_incr_addr(sel_incr_addr), .base_addr(base_addr),
    .pkt_addr(pkt_addr), .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr),
    .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst), .axi_awid(awid),
    .axi_bvalid(bvalid), .axi_bresp(bresp), .axi_bready(bready), .out_cnt(out_cnt),
    .idle(idle), .err(err));

  axi_aw_addr_gen #(.ADDR_W(32), .ID_W(4), .AXI_ID(0), .FLIT_BYTES(32), .MAX_OUT(2)) dut_t (
    .clk(clk), .rstn(rstn), .addr_valid(addr_valid), .sel_pkt_addr(sel_pkt_addr),
    .sel_base_addr(sel_base_addr), .sel_incr_addr(sel_incr_addr), .base_addr(base_addr),
    .pkt_addr(pkt_addr), .axi_awvalid(t_awvalid), .axi_awready(awready), .axi_awaddr(t_awaddr),
    .axi_awlen(t_awlen), .axi_awsize(t_awsize), .axi_awburst(t_awburst), .axi_awid(t_awid),
    .axi_bvalid(bvalid), .axi_bresp(bresp), .axi_bready(t_bready), .out_cnt(t_out_cnt),
    .idle(t_idle), .err(t_err));

  task automatic set_sel(input logic v, input logic p, input logic b, input logic i);
    addr_valid = v; sel_pkt_addr = p; sel_base_addr = b; sel_incr_addr = i;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); bvalid = 1'b1;
    end
    @(negedge clk); bvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rstn = 1'b0; set_sel(0, 0, 0, 0); bvalid = 1'b0; bresp = 2'b00;
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; set_sel(0, 0, 0, 0);
    base_addr = '0; pkt_addr = '0; awready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    #12;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got %b exp 0", awvalid); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL rst_bready got %b exp 0", bready); end
    checks++; if (out_cnt !== 8'd0 || idle !== 1'b1) begin errors++; $display("FAIL rst_cnt got %0d/%b exp 0/1", out_cnt, idle); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL rst_err got %b exp 000", err); end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); #2;
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL bready_after_rst got %b exp 1", bready); end
  endtask

  task automatic test_hdr_dat();
    logic [31:0] exp_hdr [3] = '{32'h1000, 32'h1020, 32'h1040};
    logic [31:0] exp_dat [4] = '{32'h8000, 32'h8020, 32'h8040, 32'h8060};
    @(negedge clk); base_addr = 32'h1000; pkt_addr = 32'h8000; awready = 1'b1; set_sel(1, 0, 1, 0);
    #2;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL load_awvalid got %b exp 0", awvalid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); set_sel(1, 0, 0, 1); #2;
      checks++;
      if (awvalid !== 1'b1 || awaddr !== exp_hdr[k]) begin
        errors++; $display("FAIL hdr%0d got v=%b a=%h exp v=1 a=%h", k, awvalid, awaddr, exp_hdr[k]);
      end
    end
    @(negedge clk); set_sel(1, 1, 1, 0); #2;
    checks++; if (awvalid !== 1'b1 || awaddr !== 32'h1060) begin errors++; $display("FAIL hdr_last got v=%b a=%h exp v=1 a=00001060", awvalid, awaddr); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); set_sel(1, 1, 0, 1); #2;
      checks++;
      if (awvalid !== 1'b1 || awaddr !== exp_dat[k]) begin
        errors++; $display("FAIL dat%0d got v=%b a=%h exp v=1 a=%h", k, awvalid, awaddr, exp_dat[k]);
      end
    end
    checks++;
    if (awlen !== 8'd0 || awsize !== 3'd5 || awburst !== 2'b01 || awid !== 4'd0) begin
      errors++; $display("FAIL aw_const got len=%0d size=%0d burst=%b id=%0d exp 0/5/01/0", awlen, awsize, awburst, awid);
    end
    @(negedge clk); set_sel(0, 0, 0, 0); #2;
    checks++; if (awvalid !== 1'b0 || awaddr !== 32'h0) begin errors++; $display("FAIL noissue got v=%b a=%h exp v=0 a=0", awvalid, awaddr); end
    checks++; if (out_cnt !== 8'd8 || idle !== 1'b0) begin errors++; $display("FAIL cnt_full got %0d/%b exp 8/0", out_cnt, idle); end
    drain(8); #2;
    checks++; if (out_cnt !== 8'd0 || idle !== 1'b1 || err !== 3'b000) begin errors++; $display("FAIL drain got cnt=%0d idle=%b err=%b exp 0/1/000", out_cnt, idle, err); end
  endtask

  task automatic test_stall();
    @(negedge clk); pkt_addr = 32'h8000; awready = 1'b1; set_sel(1, 0, 1, 0);
    @(negedge clk); set_sel(1, 1, 0, 1); #2;
    checks++; if (awaddr !== 32'h8000) begin errors++; $display("FAIL stall_first got %h exp 00008000", awaddr); end
    @(negedge clk); awready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++;
      if (awvalid !== 1'b1 || awaddr !== 32'h8020) begin
        errors++; $display("FAIL stall_hold%0d got v=%b a=%h exp v=1 a=00008020", c, awvalid, awaddr);
      end
      @(negedge clk);
    end
    awready = 1'b1; #2;
    checks++; if (awvalid !== 1'b1 || awaddr !== 32'h8020) begin errors++; $display("FAIL stall_release got v=%b a=%h exp v=1 a=00008020", awvalid, awaddr); end
    @(negedge clk); #2;
    checks++; if (awaddr !== 32'h8040) begin errors++; $display("FAIL stall_next got %h exp 00008040", awaddr); end
    @(negedge clk); set_sel(0, 0, 0, 0); #2;
    checks++; if (out_cnt !== 8'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", out_cnt); end
    drain(3);
  endtask

  task automatic test_wrap();
    @(negedge clk); pkt_addr = 32'hFFFF_FFE0; awready = 1'b1; set_sel(1, 0, 1, 0);
    @(negedge clk); set_sel(1, 1, 0, 1); #2;
    checks++; if (awaddr !== 32'hFFFF_FFE0) begin errors++; $display("FAIL wrap0 got %h exp ffffffe0", awaddr); end
    @(negedge clk); #2;
    checks++; if (awvalid !== 1'b1 || awaddr !== 32'h0) begin errors++; $display("FAIL wrap1 got v=%b a=%h exp v=1 a=00000000", awvalid, awaddr); end
    @(negedge clk); set_sel(0, 0, 0, 0);
    drain(2);
  endtask

  task automatic test_illegal();
    @(negedge clk); set_sel(1, 1, 1, 1); #2;
    checks++; if (awvalid !== 1'b0 || awaddr !== 32'h0) begin errors++; $display("FAIL illegal_aw got v=%b a=%h exp v=0 a=0", awvalid, awaddr); end
    @(negedge clk); set_sel(0, 0, 0, 0); #2;
    checks++; if (err !== 3'b001) begin errors++; $display("FAIL illegal_err got %b exp 001", err); end
  endtask

  task automatic test_bresp();
    @(negedge clk); awready = 1'b1; set_sel(1, 1, 0, 1);
    @(negedge clk); set_sel(0, 0, 0, 0); bvalid = 1'b1; bresp = 2'b10;
    @(negedge clk); bvalid = 1'b0; bresp = 2'b00; #2;
    checks++; if (err !== 3'b011 || out_cnt !== 8'd0) begin errors++; $display("FAIL bresp_err got err=%b cnt=%0d exp 011/0", err, out_cnt); end
    @(negedge clk); bvalid = 1'b1;
    @(negedge clk); bvalid = 1'b0; #2;
    checks++; if (err !== 3'b111 || out_cnt !== 8'd0) begin errors++; $display("FAIL b_underflow got err=%b cnt=%0d exp 111/0", err, out_cnt); end
  endtask

  task automatic test_throttle();
    pulse_reset();
    @(negedge clk); pkt_addr = 32'h8000; awready = 1'b1; set_sel(1, 0, 1, 0);
    @(negedge clk); set_sel(1, 1, 0, 1); #2;
    checks++; if (t_awvalid !== 1'b1 || t_awaddr !== 32'h8000) begin errors++; $display("FAIL thr0 got v=%b a=%h exp v=1 a=00008000", t_awvalid, t_awaddr); end
    @(negedge clk); #2;
    checks++; if (t_awvalid !== 1'b1 || t_awaddr !== 32'h8020) begin errors++; $display("FAIL thr1 got v=%b a=%h exp v=1 a=00008020", t_awvalid, t_awaddr); end
    @(negedge clk); #2;
    checks++; if (t_awvalid !== 1'b0 || t_out_cnt !== 8'd2) begin errors++; $display("FAIL thr_full got v=%b cnt=%0d exp 0/2", t_awvalid, t_out_cnt); end
    @(negedge clk); bvalid = 1'b1; #2;
    checks++; if (t_awvalid !== 1'b0) begin errors++; $display("FAIL thr_b_cycle got v=%b exp 0", t_awvalid); end
    @(negedge clk); bvalid = 1'b0; #2;
    checks++; if (t_out_cnt !== 8'd1 || t_awvalid !== 1'b1 || t_awaddr !== 32'h8040) begin errors++; $display("FAIL thr_resume got cnt=%0d v=%b a=%h exp 1/1/00008040", t_out_cnt, t_awvalid, t_awaddr); end
    @(negedge clk); bvalid = 1'b1; #2;
    checks++; if (t_awvalid !== 1'b0 || t_out_cnt !== 8'd2) begin errors++; $display("FAIL thr_full2 got v=%b cnt=%0d exp 0/2", t_awvalid, t_out_cnt); end
    @(negedge clk); #2;
    checks++; if (t_awvalid !== 1'b1 || t_awaddr !== 32'h8060 || t_out_cnt !== 8'd1) begin errors++; $display("FAIL thr_pair got v=%b a=%h cnt=%0d exp 1/00008060/1", t_awvalid, t_awaddr, t_out_cnt); end
    @(negedge clk); set_sel(0, 0, 0, 0); bvalid = 1'b0; #2;
    checks++; if (t_out_cnt !== 8'd1 || t_err !== 3'b000) begin errors++; $display("FAIL thr_both got cnt=%0d err=%b exp 1/000", t_out_cnt, t_err); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    @(negedge clk); set_sel(1, 0, 0, 0);
    @(negedge clk); pkt_addr = 32'h8000; awready = 1'b1; set_sel(1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); set_sel(1, 1, 0, 1);
    end
    @(negedge clk); awready = 1'b0; #2;
    checks++; if (awvalid !== 1'b1 || out_cnt !== 8'd3 || err !== 3'b001) begin errors++; $display("FAIL pre_rst got v=%b cnt=%0d err=%b exp 1/3/001", awvalid, out_cnt, err); end
    #1 rstn = 1'b0; #1;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_awvalid got %b exp 0", awvalid); end
    checks++; if (out_cnt !== 8'd0 || err !== 3'b000 || awaddr !== 32'h0) begin errors++; $display("FAIL mid_rst_state got cnt=%0d err=%b a=%h exp 0/000/0", out_cnt, err, awaddr); end
    @(negedge clk); rstn = 1'b1; set_sel(0, 0, 0, 0); #2;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL post_rst_idle got %b exp 1", idle); end
    @(negedge clk); awready = 1'b1; set_sel(1, 0, 0, 1); #2;
    checks++; if (awvalid !== 1'b1 || awaddr !== 32'h0) begin errors++; $display("FAIL post_rst_hdr got v=%b a=%h exp v=1 a=0", awvalid, awaddr); end
    @(negedge clk); set_sel(0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hdr_dat();
    test_stall();
    test_wrap();
    test_illegal();
    test_bresp();
    test_throttle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
